// File: rtl/freq_table_reader.sv
// Frequency-table readout: snapshots a table, then streams (symbol, count) beats with valid/ready.
// Define FREQ_TABLE_SKIP_ZERO_EN to suppress beats for zero-count entries.
module freq_table_reader #(
  parameter int TABLE_SIZE  = 256,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [COUNT_WIDTH-1:0] table_in [TABLE_SIZE],
  input  logic                   table_valid_in,
  output logic                   table_ready_out,
  output logic [7:0]             symbol_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   last_out,
  output logic                   done_out,
  output logic [8:0]             beat_count_out
);

  localparam int IDX_W = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [COUNT_WIDTH-1:0] r_snapshot [TABLE_SIZE];
  logic [IDX_W-1:0]       r_index;
  logic [IDX_W-1:0]       r_last_idx;
  logic [IDX_W-1:0]       w_last_idx;
  logic                   w_none_emittable;
  logic [8:0]             r_beat_cnt;
  logic [8:0]             w_beat_cnt_nxt;
  logic [8:0]             r_beat_count_out;
  logic [7:0]             r_symbol;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_table_ready;
  logic                   w_accept;
  logic                   w_handshake;
  logic                   w_emit_cur;
  logic                   w_is_last;
  logic                   w_valid;
  logic                   w_last;
  logic                   w_done;

  assign w_accept       = (r_state == S_IDLE) && table_valid_in && r_table_ready;
  assign w_handshake    = (r_state == S_EMIT) && ready_in;
  assign w_is_last      = (r_index == r_last_idx);
  assign w_beat_cnt_nxt = r_beat_cnt + (w_handshake ? 9'd1 : 9'd0);

`ifdef FREQ_TABLE_SKIP_ZERO_EN
  assign w_emit_cur = |r_snapshot[r_index];
`else
  assign w_emit_cur = 1'b1;
`endif

  // Highest emittable index; only consumed while in LOAD.
  always_comb begin
    w_last_idx       = LAST_IDX;
    w_none_emittable = 1'b0;
`ifdef FREQ_TABLE_SKIP_ZERO_EN
    w_last_idx       = '0;
    w_none_emittable = 1'b1;
    for (int i = 0; i < TABLE_SIZE; i++) begin
      if (r_snapshot[i] != '0) begin
        w_last_idx       = IDX_W'(i);
        w_none_emittable = 1'b0;
      end
    end
`endif
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_last       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_next_state = w_none_emittable ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        if (w_emit_cur)                w_next_state = S_EMIT;
        else if (r_index == LAST_IDX)  w_next_state = S_DONE;
      end
      S_EMIT: begin
        w_valid = 1'b1;
        w_last  = w_is_last;
        if (ready_in) w_next_state = w_is_last ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state          <= S_IDLE;
      r_index          <= '0;
      r_last_idx       <= '0;
      r_beat_cnt       <= '0;
      r_beat_count_out <= '0;
      r_symbol         <= '0;
      r_count          <= '0;
      r_table_ready    <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_table_ready <= (w_next_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_index    <= '0;
            r_beat_cnt <= '0;
          end
        end
        S_LOAD: r_last_idx <= w_last_idx;
        S_SCAN: begin
          if (w_emit_cur) begin
            r_symbol <= 8'(r_index);
            r_count  <= r_snapshot[r_index];
          end else if (r_index != LAST_IDX) begin
            r_index <= r_index + IDX_W'(1);
          end
        end
        S_EMIT: begin
          if (ready_in) begin
            r_beat_cnt <= w_beat_cnt_nxt;
            if (!w_is_last) r_index <= r_index + IDX_W'(1);
          end
        end
        default: ;
      endcase
      if (w_next_state == S_DONE) r_beat_count_out <= w_beat_cnt_nxt;
    end
  end

  // NOTE: the snapshot memory is deliberately not reset; it is always written on accept before use.
  always_ff @(posedge clk_in) begin
    if (w_accept) r_snapshot <= table_in;
  end

  assign table_ready_out = r_table_ready;
  assign symbol_out      = r_symbol;
  assign count_out       = r_count;
  assign valid_out       = w_valid;
  assign last_out        = w_last;
  assign done_out        = w_done;
  assign beat_count_out  = r_beat_count_out;

endmodule
